// File: rtl/dbus_pkg.sv
// Shared constants and helpers for the CPU data-bus bridge: peripheral
// address map, TIMER_CTL bit positions, bus source select and 7-seg decode.
package dbus_pkg;

    localparam logic [31:0] PERIPH_BASE    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIGITS    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER_CNT = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TIMER_CTL = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED       = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW        = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN       = 32'hFFFF_F078;

    localparam int unsigned CTL_EN_BIT  = 0;
    localparam int unsigned CTL_CLR_BIT = 1;

    // Which source an access is routed to.
    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_DIGITS,
        SEL_TCNT,
        SEL_TCTL,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } bus_sel_e;

    // Hex nibble to active-low {dp,g..a}; dp is always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// 8-digit multiplexed 7-segment driver: steps one digit every SCAN_DIV
// clocks and shows the matching nibble of the digits word.
module seg_scan
    import dbus_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] digits,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;
    logic          scan_wrap;
    logic [3:0]    nibble;

    // Scan prescaler and digit index next-state.
    always_comb begin
        scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
        idx_d     = scan_wrap ? idx_q + 3'd1 : idx_q;
    end

    // Scan state registers, synchronous active-low reset.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    // Digit enable and segment pattern for the current index.
    always_comb begin
        nibble  = digits[{idx_q, 2'b00} +: 4];
        dig_en  = ~(8'd1 << idx_q);
        dig_seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/dbus_bridge.sv
// CPU data-bus bridge: decodes MEM-stage accesses to external DRAM or the
// on-chip LED, switch/button, 7-segment and timer peripherals.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned DRAM_AW   = 14,
    parameter int unsigned TIMER_DIV = 25000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    bus_sel_e sel;

    logic [23:0]   led_q, led_d;
    logic [31:0]   digits_q, digits_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ten_q, ten_d;
    logic [23:0]   sw_meta_q, sw_sync_q;
    logic [4:0]    btn_meta_q, btn_sync_q;

    logic          led_we, dig_we, ctl_we;
    logic          presc_wrap;

    // Address decode: everything below the peripheral page is DRAM.
    always_comb begin
        sel = SEL_NONE;
        if (Bus_addr < PERIPH_BASE) begin
            sel = SEL_DRAM;
        end else begin
            case (Bus_addr)
                ADDR_DIGITS:    sel = SEL_DIGITS;
                ADDR_TIMER_CNT: sel = SEL_TCNT;
                ADDR_TIMER_CTL: sel = SEL_TCTL;
                ADDR_LED:       sel = SEL_LED;
                ADDR_SW:        sel = SEL_SW;
                ADDR_BTN:       sel = SEL_BTN;
                default:        sel = SEL_NONE;
            endcase
        end
    end

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        Bus_rdata = '0;
        case (sel)
            SEL_DRAM:   Bus_rdata = dram_rdata;
            SEL_DIGITS: Bus_rdata = digits_q;
            SEL_TCNT:   Bus_rdata = tcnt_q;
            SEL_TCTL:   Bus_rdata = {30'b0, ten_q, 1'b0};
            SEL_LED:    Bus_rdata = {8'b0, led_q};
            SEL_SW:     Bus_rdata = {8'b0, sw_sync_q};
            SEL_BTN:    Bus_rdata = {27'b0, btn_sync_q};
            default:    Bus_rdata = '0;
        endcase
    end

    // DRAM side and peripheral write strobes.
    always_comb begin
        dram_addr  = Bus_addr[DRAM_AW+1:2];
        dram_wdata = Bus_wdata;
        dram_we    = Bus_wen && (sel == SEL_DRAM);
        led_we     = Bus_wen && (sel == SEL_LED);
        dig_we     = Bus_wen && (sel == SEL_DIGITS);
        ctl_we     = Bus_wen && (sel == SEL_TCTL);
        led_d      = led_we ? Bus_wdata[23:0] : led_q;
        digits_d   = dig_we ? Bus_wdata : digits_q;
    end

    // Timer next-state: a clear write beats the wrap increment on the same edge.
    always_comb begin
        presc_wrap = ten_q && (presc_q == PW'(TIMER_DIV - 1));
        presc_d    = presc_q;
        tcnt_d     = tcnt_q;
        ten_d      = ten_q;
        if (ten_q) begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
        if (ctl_we) begin
            ten_d = Bus_wdata[CTL_EN_BIT];
            if (Bus_wdata[CTL_CLR_BIT]) begin
                tcnt_d  = '0;
                presc_d = '0;
            end
        end
    end

    // Peripheral registers, timer and input synchronisers.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            led_q      <= '0;
            digits_q   <= '0;
            tcnt_q     <= '0;
            presc_q    <= '0;
            ten_q      <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            led_q      <= led_d;
            digits_q   <= digits_d;
            tcnt_q     <= tcnt_d;
            presc_q    <= presc_d;
            ten_q      <= ten_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign led = led_q;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .digits  (digits_q),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: tb/tb_dbus_bridge.sv
// Self-checking bench for dbus_bridge: bus decode vector table with a
// scoreboard, then hand sequences for synchroniser, timer, scan and reset.
module tb_dbus_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    always #5 cpu_clk = ~cpu_clk;

    dbus_bridge #(
        .DRAM_AW   (14),
        .TIMER_DIV (4),
        .SCAN_DIV  (2)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic [31:0] rdata;
        logic        we;
        logic [13:0] daddr;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic [13:0] daddr;
        logic [31:0] wdata;
    } exp_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    // Expected segments for DIGITS=0x01234567 at idx 0..7 (digits 7..0).
    logic [7:0] seg_exp [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Bus_addr  = a;
        Bus_wen   = 1'b1;
        Bus_wdata = d;
        tick(1);
        Bus_wen   = 1'b0;
        Bus_wdata = '0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        Bus_addr = a;
        Bus_wen  = 1'b0;
        #1;
        check(name, Bus_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t       e;
        logic [7:0] prev_en;
        logic       found;
        int         idx;

        //            addr          wen   wdata          drd            rdata          we    daddr
        vecs[0]  = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 14'h0004};
        vecs[1]  = '{32'h0000_0010, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0, 14'h0004};
        vecs[2]  = '{32'hFFFF_F060, 1'b1, 32'hFFAB_CDEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C18};
        vecs[3]  = '{32'hFFFF_F060, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[4]  = '{32'hFFFF_F064, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C19};
        vecs[5]  = '{32'hFFFF_F060, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[6]  = '{32'hFFFF_F064, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C19};
        vecs[7]  = '{32'hFFFF_F000, 1'b1, 32'h89AB_CDEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C00};
        vecs[8]  = '{32'hFFFF_F000, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h89AB_CDEF, 1'b0, 14'h3C00};
        vecs[9]  = '{32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C1C};
        vecs[10] = '{32'hFFFF_F070, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C1C};
        vecs[11] = '{32'hFFFF_F024, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C09};
        vecs[12] = '{32'hFFFF_EFFC, 1'b1, 32'hAAAA_5555, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 14'h3BFF};
        vecs[13] = '{32'hFFFF_F004, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C01};

        seg_exp = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

        cpu_rst    = 1'b0;
        Bus_addr   = '0;
        Bus_wen    = 1'b0;
        Bus_wdata  = '0;
        dram_rdata = '0;
        sw         = '0;
        btn        = '0;
        tick(2);

        // Reset state
        check("rst.dig_en", {24'b0, dig_en}, 32'h0000_00FE);
        check("rst.dig_seg", {24'b0, dig_seg}, 32'h0000_00C0);
        check("rst.led", {8'b0, led}, 32'h0);
        bus_read("rst.tcnt", 32'hFFFF_F020, 32'h0);
        bus_read("rst.tctl", 32'hFFFF_F024, 32'h0);
        bus_read("rst.digits", 32'hFFFF_F000, 32'h0);
        cpu_rst = 1'b1;
        tick(1);

        // Decode / read-mux / write-strobe vectors through the scoreboard
        for (int i = 0; i < NV; i++) begin
            Bus_addr   = vecs[i].addr;
            Bus_wen    = vecs[i].wen;
            Bus_wdata  = vecs[i].wdata;
            dram_rdata = vecs[i].drd;
            sb_q.push_back('{vecs[i].rdata, vecs[i].we, vecs[i].daddr, vecs[i].wdata});
            #2;
            e = sb_q.pop_front();
            check($sformatf("v%0d.rdata", i), Bus_rdata, e.rdata);
            check($sformatf("v%0d.dram_we", i), {31'b0, dram_we}, {31'b0, e.we});
            check($sformatf("v%0d.dram_addr", i), {18'b0, dram_addr}, {18'b0, e.daddr});
            check($sformatf("v%0d.dram_wdata", i), dram_wdata, e.wdata);
            tick(1);
        end
        Bus_wen    = 1'b0;
        Bus_wdata  = '0;
        dram_rdata = '0;
        check("led.port", {8'b0, led}, 32'h00AB_CDEF);

        // Switch and button synchroniser latency
        Bus_addr = 32'hFFFF_F070;
        sw = 24'h000F0F;
        bus_read("sw.edge0", 32'hFFFF_F070, 32'h0);
        tick(1);
        bus_read("sw.edge1", 32'hFFFF_F070, 32'h0);
        tick(1);
        bus_read("sw.edge2", 32'hFFFF_F070, 32'h0000_0F0F);
        btn = 5'h15;
        bus_read("btn.edge0", 32'hFFFF_F078, 32'h0);
        tick(1);
        bus_read("btn.edge1", 32'hFFFF_F078, 32'h0);
        tick(1);
        bus_read("btn.edge2", 32'hFFFF_F078, 32'h0000_0015);

        // Timer: enable, count, clear, hold, clear-beats-increment
        bus_write(32'hFFFF_F024, 32'h1);
        tick(3);
        bus_read("tmr.3cyc", 32'hFFFF_F020, 32'd0);
        tick(1);
        bus_read("tmr.4cyc", 32'hFFFF_F020, 32'd1);
        tick(8);
        bus_read("tmr.12cyc", 32'hFFFF_F020, 32'd3);
        bus_read("tmr.ctl_en", 32'hFFFF_F024, 32'h2);
        bus_write(32'hFFFF_F024, 32'h3);
        bus_read("tmr.clear", 32'hFFFF_F020, 32'd0);
        tick(4);
        bus_read("tmr.after_clr", 32'hFFFF_F020, 32'd1);
        tick(2);
        bus_write(32'hFFFF_F024, 32'h0);
        bus_read("tmr.stop", 32'hFFFF_F020, 32'd1);
        tick(10);
        bus_read("tmr.hold", 32'hFFFF_F020, 32'd1);
        bus_read("tmr.ctl_dis", 32'hFFFF_F024, 32'h0);
        bus_write(32'hFFFF_F024, 32'h1);
        bus_write(32'hFFFF_F024, 32'h3);
        bus_read("tmr.clr_prio", 32'hFFFF_F020, 32'd0);
        tick(3);
        bus_read("tmr.prio_3", 32'hFFFF_F020, 32'd0);
        tick(1);
        bus_read("tmr.prio_4", 32'hFFFF_F020, 32'd1);

        // Display scan: align to the entry into digit 0, then follow 8 digits
        bus_write(32'hFFFF_F000, 32'h0123_4567);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            prev_en = dig_en;
            tick(1);
            if (prev_en != 8'hFE && dig_en == 8'hFE) found = 1'b1;
        end
        check("scan.align", {31'b0, found}, 32'h1);
        for (int s = 0; s < 17; s++) begin
            idx = (s / 2) % 8;
            check($sformatf("scan%0d.dig_en", s), {24'b0, dig_en}, {24'b0, ~(8'd1 << idx)});
            check($sformatf("scan%0d.dig_seg", s), {24'b0, dig_seg}, {24'b0, seg_exp[idx]});
            tick(1);
        end

        // Reset in the middle of operation; writes during reset are dropped
        bus_write(32'hFFFF_F060, 32'h55);
        bus_write(32'hFFFF_F024, 32'h1);
        tick(6);
        check("pre_rst.led", {8'b0, led}, 32'h55);
        cpu_rst   = 1'b0;
        Bus_addr  = 32'hFFFF_F060;
        Bus_wen   = 1'b1;
        Bus_wdata = 32'hFFFF_FFFF;
        #1;
        check("rst2.periph_we", {31'b0, dram_we}, 32'h0);
        tick(1);
        check("rst2.led", {8'b0, led}, 32'h0);
        check("rst2.dig_en", {24'b0, dig_en}, 32'h0000_00FE);
        Bus_addr = 32'h0000_0020;
        #1;
        check("rst2.dram_we", {31'b0, dram_we}, 32'h1);
        Bus_addr  = 32'hFFFF_F024;
        Bus_wdata = 32'h1;
        tick(1);
        Bus_wen   = 1'b0;
        Bus_wdata = '0;
        bus_read("rst2.tctl", 32'hFFFF_F024, 32'h0);
        bus_read("rst2.tcnt", 32'hFFFF_F020, 32'h0);
        bus_read("rst2.led_rd", 32'hFFFF_F060, 32'h0);
        bus_read("rst2.digits", 32'hFFFF_F000, 32'h0);
        cpu_rst = 1'b1;
        tick(6);
        bus_read("post_rst.tcnt", 32'hFFFF_F020, 32'h0);
        bus_read("post_rst.led", 32'hFFFF_F060, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Data-bus bridge directly downstream of the CPU's MEM stage; consumes Bus_addr/Bus_wen/Bus_wdata and returns Bus_rdata.
- Decodes the address and routes each access to the external DRAM or to on-chip peripherals: LED register, synchronised switches/buttons, 8-digit 7-segment display, and a prescaled timer.
- The 7-segment display includes a scanning driver.

Parameters:
- DRAM_AW, 14, DRAM word-address width; dram_addr = Bus_addr[DRAM_AW+1:2].
- TIMER_DIV, 25000, cpu_clk cycles per timer tick (1 ms at 25 MHz).
- SCAN_DIV, 50000, cpu_clk cycles per display digit step.

Ports:
- cpu_clk  in  1  single clock; all state updates on rising edge.
- cpu_rst  in  1  reset, synchronous, active-low.
- Bus_addr  in  32  byte address from the CPU MEM stage.
- Bus_wen  in  1  write strobe, word writes only.
- Bus_wdata  in  32  write data.
- Bus_rdata  out  32  read data, combinational, same cycle.
- dram_addr  out  DRAM_AW  DRAM word address.
- dram_we  out  1  DRAM write enable.
- dram_wdata  out  32  DRAM write data (= Bus_wdata).
- dram_rdata  in  32  DRAM read data, combinational.
- sw  in  24  raw switches, asynchronous.
- btn  in  5  raw buttons, asynchronous.
- led  out  24  LED register.
- dig_en  out  8  digit enables, active-low, one-hot-low.
- dig_seg  out  8  {dp,g..a} segments, active-low.

Behaviour:
- Address map:
  - Addresses below 0xFFFF_F000 select DRAM.
  - 0xFFFF_F000 DIGITS, R/W, 8 hex nibbles; nibble 0 drives the rightmost digit.
  - 0xFFFF_F020 TIMER_CNT, RO.
  - 0xFFFF_F024 TIMER_CTL, W: bit0 enable, bit1 clear. Read returns {30'b0, en, 1'b0}.
  - 0xFFFF_F060 LED, R/W, low 24 bits.
  - 0xFFFF_F070 SW, RO, zero-extended.
  - 0xFFFF_F078 BTN, RO, zero-extended.
  - Any other 0xFFFF_Fxxx address is unmapped.
- Reads: Bus_rdata is a pure combinational mux of the decoded source, with no added latency. Unmapped reads return 0.
- Writes:
  - dram_we = Bus_wen & DRAM hit, combinational.
  - Peripheral registers update on the edge where Bus_wen & hit.
  - Writes to unmapped or RO addresses are ignored.
  - A read in the cycle after a write returns the new value.
- sw and btn pass through a 2-flop synchroniser. A raw change is visible on Bus_rdata 2 edges later.
- Timer:
  - A prescale counter counts 0..TIMER_DIV-1 while en=1.
  - On the wrap edge TIMER_CNT increments, wrapping 0xFFFF_FFFF to 0.
  - en=0 holds both counters.
  - A write with clear=1 zeroes TIMER_CNT and the prescaler on that edge. Clear has priority over the increment in the same edge.
  - en takes the written bit0 on the same edge as the clear.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1; on wrap the digit index advances 0..7 and wraps to 0.
  - dig_en = ~(1 << idx).
  - dig_seg = hex→7-seg(DIGITS[4*idx+3:4*idx]), with dp=1 (off).
- Reset (cpu_rst=0 at an edge):
  - led=0, DIGITS=0, TIMER_CNT=0, prescaler=0, en=0.
  - Synchroniser flops=0, scan counter=0, idx=0.
  - Hence dig_en=8'hFE and dig_seg shows "0" (8'hC0).
  - Reset mid-count aborts the count immediately. Writes during reset are ignored.
  - dram_we still follows Bus_wen combinationally; the CPU's own reset keeps Bus_wen low.

Decomposition:
- Package dbus_pkg holds:
  - address constants (PERIPH_BASE, ADDR_DIGITS, ADDR_TIMER_CNT, ADDR_TIMER_CTL, ADDR_LED, ADDR_SW, ADDR_BTN);
  - TIMER_CTL bit indices;
  - a function hex_to_seg (16-entry active-low table: 0→C0, 1→F9, … F→8E).
- One sub-module, seg_scan: scan counter, digit index and segment decode. Inputs are cpu_clk, cpu_rst and digits[31:0]; outputs are dig_en and dig_seg; parameter SCAN_DIV.
- Decode, registers, synchroniser and timer stay in dbus_bridge.

Test Plan:
1. DRAM routing: write 0x1234_5678 to 0x0000_0010, then read the same address → dram_we=1 for exactly that cycle, dram_addr=4, and with dram_rdata=0x1234_5678 Bus_rdata=0x1234_5678 combinationally.
2. LED: write 0xFFAB_CDEF to 0xFFFF_F060 → led=0xABCDEF after the edge; read returns 0x00AB_CDEF. A write to 0xFFFF_F064 leaves led unchanged and reads 0.
3. Switch sync: sw goes 0→0x00_0F0F → reading 0xFFFF_F070 returns 0 for 1 edge and 0x0000_0F0F from the 2nd edge.
4. Timer (TIMER_DIV=4): write CTL=1 → TIMER_CNT=1 after 4 cycles and 3 after 12 cycles. Write CTL=3 → 0 on that edge, counting continues. Write CTL=0 → value holds. Preset count 0xFFFF_FFFF → wraps to 0.
5. Display (SCAN_DIV=2): write DIGITS=0x0123_4567 → dig_en steps FE,FD,…,7F,FE every 2 cycles; dig_seg is F8 ("7") at idx0 and C0 ("0") at idx7.
6. Reset mid-operation: assert cpu_rst=0 with timer running and led=0x55 → next edge: TIMER_CNT=0, en=0, led=0, dig_en=FE; all writes are ignored while cpu_rst=0.
